// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4 read arbiter: IC and DC share one AR/R channel.
// One outstanding burst at a time; R beats are registered back to the owner.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ic_rd_req/addr, ic_rd_rdy        IC request side (rdy is a 1-cycle pulse)
//   ic_ret_valid/last/data           IC return beats
//   dc_rd_req/addr/uncached, rdy     DC request side
//   dc_ret_valid/last/data           DC return beats
//   arvalid/arready/araddr/arid/
//   arlen/arsize/arburst             AXI read address channel
//   rvalid/rready/rdata/rid/
//   rlast/rresp                      AXI read data channel
//   rd_err                           sticky protocol/response error
module axi_rd_arbiter #(
  parameter int         ID_W   = 4,
  parameter logic [7:0] IC_LEN = 8'd3,
  parameter logic [7:0] DC_LEN = 8'd3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ic_rd_req,
  input  logic [31:0]     ic_rd_addr,
  output logic            ic_rd_rdy,
  output logic            ic_ret_valid,
  output logic            ic_ret_last,
  output logic [31:0]     ic_ret_data,
  input  logic            dc_rd_req,
  input  logic [31:0]     dc_rd_addr,
  input  logic            dc_rd_uncached,
  output logic            dc_rd_rdy,
  output logic            dc_ret_valid,
  output logic            dc_ret_last,
  output logic [31:0]     dc_ret_data,
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [ID_W-1:0] arid,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  input  logic            rvalid,
  output logic            rready,
  input  logic [31:0]     rdata,
  input  logic [ID_W-1:0] rid,
  input  logic            rlast,
  input  logic [1:0]      rresp,
  output logic            rd_err
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t     state;
  logic       ptr;
  logic       gnt_dc;
  logic [7:0] cnt;

  logic       pick_dc;
  logic       len_hit;
  logic       beat_last;
  logic       beat_err;

  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  // ptr=1 favours DC when both request
  assign pick_dc = dc_rd_req && (!ic_rd_req || ptr);

  // A beat at the expected count ends the burst even without rlast
  assign len_hit   = (cnt == arlen);
  assign beat_last = rlast || len_hit;
  assign beat_err  = (rresp != 2'b00) ||
                     (rid != arid) ||
                     (rlast != len_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      gnt_dc       <= 1'b0;
      cnt          <= 8'd0;
      arvalid      <= 1'b0;
      araddr       <= 32'd0;
      arid         <= '0;
      arlen        <= 8'd0;
      rready       <= 1'b0;
      ic_rd_rdy    <= 1'b0;
      dc_rd_rdy    <= 1'b0;
      ic_ret_valid <= 1'b0;
      ic_ret_last  <= 1'b0;
      ic_ret_data  <= 32'd0;
      dc_ret_valid <= 1'b0;
      dc_ret_last  <= 1'b0;
      dc_ret_data  <= 32'd0;
      rd_err       <= 1'b0;
    end else begin
      ic_rd_rdy    <= 1'b0;
      dc_rd_rdy    <= 1'b0;
      ic_ret_valid <= 1'b0;
      ic_ret_last  <= 1'b0;
      dc_ret_valid <= 1'b0;
      dc_ret_last  <= 1'b0;

      unique case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (ic_rd_req || dc_rd_req) begin
            gnt_dc  <= pick_dc;
            arvalid <= 1'b1;
            state   <= ADDR;
            if (pick_dc) begin
              dc_rd_rdy <= 1'b1;
              araddr    <= dc_rd_addr;
              arid      <= ID_W'(1);
              arlen     <= dc_rd_uncached ?
                           8'd0 : DC_LEN;
            end else begin
              ic_rd_rdy <= 1'b1;
              araddr    <= ic_rd_addr;
              arid      <= '0;
              arlen     <= IC_LEN;
            end
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (rvalid) begin
            cnt <= cnt + 8'd1;
            if (gnt_dc) begin
              dc_ret_valid <= 1'b1;
              dc_ret_last  <= beat_last;
              dc_ret_data  <= rdata;
            end else begin
              ic_ret_valid <= 1'b1;
              ic_ret_last  <= beat_last;
              ic_ret_data  <= rdata;
            end
            if (beat_err)
              rd_err <= 1'b1;
            if (beat_last) begin
              rready <= 1'b0;
              ptr    <= ~gnt_dc;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter.
// Inputs change and outputs are sampled on the falling edge.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_rd_req;
  logic [31:0] ic_rd_addr;
  logic        ic_rd_rdy;
  logic        ic_ret_valid;
  logic        ic_ret_last;
  logic [31:0] ic_ret_data;
  logic        dc_rd_req;
  logic [31:0] dc_rd_addr;
  logic        dc_rd_uncached;
  logic        dc_rd_rdy;
  logic        dc_ret_valid;
  logic        dc_ret_last;
  logic [31:0] dc_ret_data;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic        rlast;
  logic [1:0]  rresp;
  logic        rd_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(
    .ID_W   (4),
    .IC_LEN (8'd3),
    .DC_LEN (8'd3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ic_rd_req      (ic_rd_req),
    .ic_rd_addr     (ic_rd_addr),
    .ic_rd_rdy      (ic_rd_rdy),
    .ic_ret_valid   (ic_ret_valid),
    .ic_ret_last    (ic_ret_last),
    .ic_ret_data    (ic_ret_data),
    .dc_rd_req      (dc_rd_req),
    .dc_rd_addr     (dc_rd_addr),
    .dc_rd_uncached (dc_rd_uncached),
    .dc_rd_rdy      (dc_rd_rdy),
    .dc_ret_valid   (dc_ret_valid),
    .dc_ret_last    (dc_ret_last),
    .dc_ret_data    (dc_ret_data),
    .arvalid        (arvalid),
    .arready        (arready),
    .araddr         (araddr),
    .arid           (arid),
    .arlen          (arlen),
    .arsize         (arsize),
    .arburst        (arburst),
    .rvalid         (rvalid),
    .rready         (rready),
    .rdata          (rdata),
    .rid            (rid),
    .rlast          (rlast),
    .rresp          (rresp),
    .rd_err         (rd_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Wait for arvalid and check the captured request
  task automatic wait_ar(input bit dc,
                         input logic [31:0] addr,
                         input logic [7:0] len);
    for (int k = 0; k < 20 && !arvalid; k++)
      cyc();
    chk("ar_seen", arvalid, 1);
    chk("araddr", araddr, addr);
    chk("arid", arid, dc ? 1 : 0);
    chk("arlen", arlen, len);
    chk("ic_rdy", ic_rd_rdy, !dc);
    chk("dc_rdy", dc_rd_rdy, dc);
  endtask

  // Accept AR, then drive nb beats; gap inserts idle cycles
  task automatic serve(input bit dc,
                       input logic [3:0] id,
                       input int nb,
                       input bit gap,
                       input int err_beat,
                       input logic [31:0] base);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    chk("rready", rready, 1);
    chk("ar_drop", arvalid, 0);
    for (int i = 0; i < nb; i++) begin
      rvalid = 1'b1;
      rdata  = base + 32'(i);
      rid    = id;
      rlast  = (i == nb - 1);
      rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      cyc();
      chk(dc ? "dc_vld" : "ic_vld",
          dc ? dc_ret_valid : ic_ret_valid, 1);
      chk(dc ? "dc_data" : "ic_data",
          dc ? dc_ret_data : ic_ret_data,
          base + 32'(i));
      chk(dc ? "dc_last" : "ic_last",
          dc ? dc_ret_last : ic_ret_last,
          (i == nb - 1));
      chk("other_vld",
          dc ? ic_ret_valid : dc_ret_valid, 0);
      if (gap && i < nb - 1) begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        cyc();
        chk("gap_ic", ic_ret_valid, 0);
        chk("gap_dc", dc_ret_valid, 0);
      end
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    ic_rd_req      = 1'b0;
    ic_rd_addr     = 32'd0;
    dc_rd_req      = 1'b0;
    dc_rd_addr     = 32'd0;
    dc_rd_uncached = 1'b0;
    arready        = 1'b0;
    rvalid         = 1'b0;
    rdata          = 32'd0;
    rid            = 4'd0;
    rlast          = 1'b0;
    rresp          = 2'b00;
    do_reset();

    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_ic_rdy", ic_rd_rdy, 0);
    chk("rst_ic_vld", ic_ret_valid, 0);
    chk("rst_dc_vld", dc_ret_valid, 0);
    chk("rst_err", rd_err, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("arsize", arsize, 3'b010);
    chk("arburst", arburst, 2'b01);

    // 1: IC only
    ic_rd_req  = 1'b1;
    ic_rd_addr = 32'h1C00_0000;
    wait_ar(0, 32'h1C00_0000, 8'd3);
    ic_rd_req = 1'b0;
    serve(0, 4'd0, 4, 0, -1, 32'hA0);
    cyc();
    chk("t1_idle_vld", ic_ret_valid, 0);
    chk("t1_err", rd_err, 0);

    // 2: simultaneous requests, then strict alternation
    do_reset();
    ic_rd_addr = 32'h100;
    dc_rd_addr = 32'h200;
    ic_rd_req  = 1'b1;
    dc_rd_req  = 1'b1;
    for (int r = 0; r < 6; r++) begin
      wait_ar(r[0], r[0] ? 32'h200 : 32'h100, 8'd3);
      if (r == 5) begin
        ic_rd_req = 1'b0;
        dc_rd_req = 1'b0;
      end
      serve(r[0], r[0] ? 4'd1 : 4'd0, 4, 0, -1,
            32'h1000 * (r + 1));
    end

    // 3: DC uncached single beat
    dc_rd_req      = 1'b1;
    dc_rd_uncached = 1'b1;
    dc_rd_addr     = 32'h8000;
    wait_ar(1, 32'h8000, 8'd0);
    dc_rd_req      = 1'b0;
    dc_rd_uncached = 1'b0;
    serve(1, 4'd1, 1, 0, -1, 32'h55);
    chk("t3_err", rd_err, 0);

    // 4: AR stall and R gaps
    ic_rd_req  = 1'b1;
    ic_rd_addr = 32'h2000_0040;
    wait_ar(0, 32'h2000_0040, 8'd3);
    ic_rd_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("stall_vld", arvalid, 1);
      chk("stall_addr", araddr, 32'h2000_0040);
      chk("stall_id", arid, 0);
      chk("stall_len", arlen, 3);
    end
    serve(0, 4'd0, 4, 1, -1, 32'hB0);
    chk("t4_err", rd_err, 0);

    // 5a: error response on beat 2, sticky
    ic_rd_req  = 1'b1;
    ic_rd_addr = 32'h300;
    wait_ar(0, 32'h300, 8'd3);
    ic_rd_req = 1'b0;
    serve(0, 4'd0, 4, 0, 2, 32'hC0);
    chk("t5_err", rd_err, 1);
    dc_rd_req  = 1'b1;
    dc_rd_addr = 32'h400;
    wait_ar(1, 32'h400, 8'd3);
    dc_rd_req = 1'b0;
    serve(1, 4'd1, 4, 0, -1, 32'hD0);
    chk("t5_sticky", rd_err, 1);

    // 5b: early rlast on beat 1 of 4
    do_reset();
    chk("t5_clr", rd_err, 0);
    ic_rd_req  = 1'b1;
    ic_rd_addr = 32'h500;
    wait_ar(0, 32'h500, 8'd3);
    ic_rd_req = 1'b0;
    serve(0, 4'd0, 1, 0, -1, 32'hE0);
    chk("t5_early", rd_err, 1);

    // 6: reset mid-burst, then DC read
    do_reset();
    ic_rd_req  = 1'b1;
    ic_rd_addr = 32'h600;
    wait_ar(0, 32'h600, 8'd3);
    ic_rd_req = 1'b0;
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'hF0;
    rid     = 4'd0;
    cyc();
    chk("t6_b0", ic_ret_valid, 1);
    rdata = 32'hF1;
    rst   = 1'b1;
    cyc();
    rst    = 1'b0;
    rvalid = 1'b0;
    chk("t6_arvalid", arvalid, 0);
    chk("t6_rready", rready, 0);
    chk("t6_ic_vld", ic_ret_valid, 0);
    chk("t6_ic_last", ic_ret_last, 0);
    chk("t6_dc_vld", dc_ret_valid, 0);
    chk("t6_rdy", ic_rd_rdy | dc_rd_rdy, 0);
    chk("t6_err", rd_err, 0);
    chk("t6_araddr", araddr, 0);
    cyc();
    chk("t6_quiet", ic_ret_valid, 0);
    dc_rd_req  = 1'b1;
    dc_rd_addr = 32'h700;
    wait_ar(1, 32'h700, 8'd3);
    dc_rd_req = 1'b0;
    serve(1, 4'd1, 4, 0, -1, 32'h70);
    chk("t6_err_end", rd_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
